// File: rtl/alu_mdu_if.sv
// Execute-stage bus for alu_mdu: ALU operands/result plus the MDU request,
// status and HI/LO architectural registers.
interface alu_mdu_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] C;
    logic             md_start;
    logic [2:0]       md_op;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side drives operands and requests, observes results.
    modport master (
        output A, B, ALUOp, md_start, md_op, flush,
        input  C, busy, done, hi, lo
    );

    // Execute unit side.
    modport slave (
        input  A, B, ALUOp, md_start, md_op, flush,
        output C, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// Execute unit: combinational ALU plus an iterative multiply/divide unit that
// owns HI/LO. Multiply is shift-add, divide is restoring; both run on operand
// magnitudes and are sign-corrected in a final FIX cycle. busy is high for
// WIDTH+1 cycles per MDU operation and done pulses on the edge that writes HI/LO.
module alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rstn,
    alu_mdu_if.slave    bus
);

    localparam int HALF = WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // ---------------------------------------------------------------- ALU
    logic [WIDTH-1:0]   c_s;
    logic [SHAMT_W-1:0] shamt_s;

    // Single-cycle ALU; unused opcodes produce zero.
    always_comb begin
        c_s     = '0;
        shamt_s = bus.A[SHAMT_W-1:0];
        case (bus.ALUOp)
            4'h0:    c_s = bus.A + bus.B;
            4'h1:    c_s = bus.A - bus.B;
            4'h2:    c_s = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            4'h3:    c_s = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            4'h4:    c_s = bus.A ^ bus.B;
            4'h5:    c_s = bus.A & bus.B;
            4'h6:    c_s = bus.A | bus.B;
            4'h7:    c_s = ~(bus.A | bus.B);
            4'h8:    c_s = {bus.B[HALF-1:0], {HALF{1'b0}}};
            4'h9:    c_s = bus.B << shamt_s;
            4'hA:    c_s = bus.B >> shamt_s;
            4'hB:    c_s = $signed(bus.B) >>> shamt_s;
            default: c_s = '0;
        endcase
    end

    assign bus.C = c_s;

    // ---------------------------------------------------------------- MDU
    state_t               state_r, state_s;
    logic [SHAMT_W-1:0]   cnt_r, cnt_s;
    logic [2*WIDTH-1:0]   prod_r, prod_s;     // {remainder|product hi, quotient|product lo}
    logic [WIDTH-1:0]     mcand_r, mcand_s;   // |B|: multiplicand or divisor magnitude
    logic                 is_div_r, is_div_s;
    logic                 sa_r, sa_s;         // A negative (signed ops only)
    logic                 sb_r, sb_s;         // B negative (signed ops only)
    logic                 dzero_r, dzero_s;
    logic [WIDTH-1:0]     dvd_r, dvd_s;       // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]     hi_r, hi_s;
    logic [WIDTH-1:0]     lo_r, lo_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;

    logic                 op_signed_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;

    // Operand magnitudes and sign flags for an incoming signed/unsigned request.
    always_comb begin
        op_signed_s = ~bus.md_op[0];
        a_neg_s     = op_signed_s & bus.A[WIDTH-1];
        b_neg_s     = op_signed_s & bus.B[WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = -bus.A;
        end else begin
            a_mag_s = bus.A;
        end
        if (b_neg_s) begin
            b_mag_s = -bus.B;
        end else begin
            b_mag_s = bus.B;
        end
    end

    logic [WIDTH-1:0]     mul_add_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_step_s;
    logic [WIDTH:0]       div_trial_s;
    logic [WIDTH:0]       div_diff_s;
    logic [2*WIDTH-1:0]   div_step_s;

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        if (prod_r[0]) begin
            mul_add_s = mcand_r;
        end else begin
            mul_add_s = '0;
        end
        mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mul_add_s};
        mul_step_s  = {mul_sum_s, prod_r[WIDTH-1:1]};

        div_trial_s = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-1]};
        div_diff_s  = div_trial_s - {1'b0, mcand_r};
        if (!div_diff_s[WIDTH]) begin
            div_step_s = {div_diff_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
        end else begin
            div_step_s = {div_trial_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b0};
        end
    end

    logic [2*WIDTH-1:0]   prod_neg_s;
    logic [WIDTH-1:0]     quo_neg_s;
    logic [WIDTH-1:0]     rem_neg_s;
    logic [WIDTH-1:0]     fix_hi_s;
    logic [WIDTH-1:0]     fix_lo_s;

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_neg_s = -prod_r;
        quo_neg_s  = -prod_r[WIDTH-1:0];
        rem_neg_s  = -prod_r[2*WIDTH-1:WIDTH];
        if (!is_div_r) begin
            if (sa_r ^ sb_r) begin
                fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
                fix_lo_s = prod_neg_s[WIDTH-1:0];
            end else begin
                fix_hi_s = prod_r[2*WIDTH-1:WIDTH];
                fix_lo_s = prod_r[WIDTH-1:0];
            end
        end else if (dzero_r) begin
            fix_hi_s = dvd_r;
            fix_lo_s = '1;
        end else begin
            if (sa_r ^ sb_r) begin
                fix_lo_s = quo_neg_s;
            end else begin
                fix_lo_s = prod_r[WIDTH-1:0];
            end
            if (sa_r) begin
                fix_hi_s = rem_neg_s;
            end else begin
                fix_hi_s = prod_r[2*WIDTH-1:WIDTH];
            end
        end
    end

    // MDU next-state and datapath updates; flush always wins over a request.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        prod_s   = prod_r;
        mcand_s  = mcand_r;
        is_div_s = is_div_r;
        sa_s     = sa_r;
        sb_s     = sb_r;
        dzero_s  = dzero_r;
        dvd_s    = dvd_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.md_start && !bus.flush) begin
                    case (bus.md_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_s  = ST_ITER;
                            cnt_s    = '0;
                            is_div_s = bus.md_op[1];
                            sa_s     = a_neg_s;
                            sb_s     = b_neg_s;
                            mcand_s  = b_mag_s;
                            prod_s   = {{WIDTH{1'b0}}, a_mag_s};
                            dzero_s  = (bus.B == '0);
                            dvd_s    = bus.A;
                        end
                        3'd4:    hi_s = bus.A;
                        3'd5:    lo_s = bus.A;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (bus.flush) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end else begin
                    if (is_div_r) begin
                        prod_s = div_step_s;
                    end else begin
                        prod_s = mul_step_s;
                    end
                    if (cnt_r == SHAMT_W'(WIDTH - 1)) begin
                        state_s = ST_FIX;
                        cnt_s   = '0;
                    end else begin
                        cnt_s   = cnt_r + SHAMT_W'(1);
                    end
                end
            end
            ST_FIX: begin
                state_s = ST_IDLE;
                if (bus.flush) begin
                    done_s = 1'b0;
                end else begin
                    hi_s   = fix_hi_s;
                    lo_s   = fix_lo_s;
                    done_s = 1'b1;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // MDU state, datapath and architectural registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            prod_r   <= '0;
            mcand_r  <= '0;
            is_div_r <= 1'b0;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            dzero_r  <= 1'b0;
            dvd_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            prod_r   <= prod_s;
            mcand_r  <= mcand_s;
            is_div_r <= is_div_s;
            sa_r     <= sa_s;
            sb_r     <= sb_s;
            dzero_r  <= dzero_s;
            dvd_r    <= dvd_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule
